// File: rtl/seq_mul64.sv
// ----------------------------------------------------------------------------
// seq_mul64 : iterative unsigned 64x64 -> 128 shift-and-add multiplier.
//
// One accumulate per clock through a 64-bit lookahead carry adder
// (LCUAdder64). Each iteration adds the multiplicand (gated by the current
// low multiplier bit) to the upper half of the accumulator and shifts the
// whole 129-bit result right by one. A fixed 64 iterations run per product.
//
// Ports (seq_mul64):
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b present
//   in_ready   block can accept operands (IDLE only)
//   a, b       multiplicand, multiplier
//   out_valid  product valid, held until out_ready
//   out_ready  consumer accepts product
//   prod_hi    upper 64 bits of product (zero unless DONE)
//   prod_lo    lower 64 bits of product (zero unless DONE)
//   hi_nz      prod_hi != 0 (unsigned overflow flag)
//   busy       state != IDLE
// ----------------------------------------------------------------------------

// 4-bit lookahead carry unit: carries into positions 1..3 plus group
// generate/propagate for the next level up.
module lcu4 (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_ci,
    output logic [2:0] o_c,
    output logic       o_g,
    output logic       o_p
);
    assign o_c[0] = i_g[0] | (i_p[0] & i_ci);
    assign o_c[1] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_ci);
    assign o_c[2] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_ci);
    assign o_g    = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                  | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_p    = &i_p;
endmodule

// 64-bit adder built as a three-level tree of lcu4 units
// (16 nibble groups -> 4 blocks -> 1 top unit).
module LCUAdder64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_cin,
    output logic [63:0] o_sum,
    output logic        o_cout
);
    logic [63:0] w_g;
    logic [63:0] w_p;
    logic [63:0] w_c;       // carry into each bit
    logic [15:0] w_gg;      // nibble-group generate / propagate / carry-in
    logic [15:0] w_gp;
    logic [15:0] w_gc;
    logic [3:0]  w_bg;      // block generate / propagate / carry-in
    logic [3:0]  w_bp;
    logic [3:0]  w_bc;
    logic        w_tg;
    logic        w_tp;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Level 1: carries inside each nibble
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_nib
            assign w_c[4*gi] = w_gc[gi];
            lcu4 u_lcu (
                .i_g  (w_g[4*gi +: 4]),
                .i_p  (w_p[4*gi +: 4]),
                .i_ci (w_gc[gi]),
                .o_c  (w_c[4*gi+1 +: 3]),
                .o_g  (w_gg[gi]),
                .o_p  (w_gp[gi])
            );
        end

        // Level 2: nibble carries inside each 16-bit block
        for (gi = 0; gi < 4; gi++) begin : g_blk
            assign w_gc[4*gi] = w_bc[gi];
            lcu4 u_lcu (
                .i_g  (w_gg[4*gi +: 4]),
                .i_p  (w_gp[4*gi +: 4]),
                .i_ci (w_bc[gi]),
                .o_c  (w_gc[4*gi+1 +: 3]),
                .o_g  (w_bg[gi]),
                .o_p  (w_bp[gi])
            );
        end
    endgenerate

    // Level 3: block carries across the full word
    assign w_bc[0] = i_cin;
    lcu4 u_top (
        .i_g  (w_bg),
        .i_p  (w_bp),
        .i_ci (i_cin),
        .o_c  (w_bc[3:1]),
        .o_g  (w_tg),
        .o_p  (w_tp)
    );

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_tg | (w_tp & i_cin);
endmodule

module seq_mul64 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             hi_nz,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Partial product is the multiplicand when the multiplier LSB is set
    assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

    LCUAdder64 u_add (
        .i_a    (r_acc_hi),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        prod_hi      = '0;
        prod_lo      = '0;
        hi_nz        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                prod_hi   = r_acc_hi;
                prod_lo   = r_acc_lo;
                hi_nz     = |r_acc_hi;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    // Shift the 129-bit {cout, sum, acc_lo} right by one;
                    // the adder carry becomes the new MSB so nothing is lost.
                    r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul64.sv
// ----------------------------------------------------------------------------
// tb_seq_mul64 : self-checking bench for seq_mul64.
// Table of operand/expected records applied in a loop, scoreboard queue of
// expected products, plus hand-written reset and reset-mid-run sequences.
// ----------------------------------------------------------------------------
module tb_seq_mul64;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  prod_hi;
    logic [63:0]  prod_lo;
    logic         hi_nz;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_mul64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .hi_nz     (hi_nz),
        .busy      (busy)
    );

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
        logic         exp_nz;
        int           hold;     // cycles of out_ready=0 stall in DONE
    } vec_t;

    typedef struct {
        logic [127:0] prod;
        logic         nz;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] va, input logic [63:0] vb, input int hold);
        vec_t v;
        v.a      = va;
        v.b      = vb;
        v.exp    = {64'd0, va} * {64'd0, vb};
        v.exp_nz = (v.exp[127:64] != 64'd0);
        v.hold   = hold;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure latency, optionally stall, then consume.
    task automatic run_op(input string name, input logic [63:0] va, input logic [63:0] vb,
                          input logic [127:0] exp, input logic exp_nz, input int hold);
        int  n;
        sb_t e;
        sb_t got;
        chk({name, ".in_ready"}, {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        a = va;
        b = vb;
        @(posedge clk);
        e.prod = exp;
        e.nz   = exp_nz;
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a = $urandom();
        b = $urandom();
        chk({name, ".run_prod_zero"}, {prod_hi, prod_lo}, 128'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({name, ".latency"}, 128'(n), 128'd64);
        got.prod = {prod_hi, prod_lo};
        got.nz   = hi_nz;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a = $urandom();
            b = $urandom();
            tick();
            chk({name, ".stall"}, {1'b0, in_ready, ~out_valid, prod_hi, prod_lo[63:3]},
                {3'b000, got.prod[127:3]});
            chk({name, ".stall_lo"}, {125'd0, prod_lo[2:0]}, {125'd0, got.prod[2:0]});
        end
        in_valid = 1'b0;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({name, ".prod"}, {prod_hi, prod_lo}, e.prod);
            chk({name, ".hi_nz"}, {127'd0, hi_nz}, {127'd0, e.nz});
        end else begin
            chk({name, ".sb_empty"}, 128'd1, 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, ".post_consume"}, {126'd0, out_valid, in_ready}, 128'd1);
        $display("op %-10s a=%h b=%h prod=%h_%h nz=%0d lat=%0d hold=%0d",
                 name, va, vb, got.prod[127:64], got.prod[63:0], got.nz, n, hold);
    endtask

    initial begin
        int n;
        logic seen;
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, 1'b1, 0};
        vecs[1] = '{64'h1000_0000, 64'h1000,
                    {64'h0, 64'h0000_0100_0000_0000}, 1'b0, 0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h2,
                    {64'h1, 64'h0}, 1'b1, 0};
        vecs[3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0, 1'b0, 0};
        vecs[4] = '{64'hDEAD_BEEF_0123_4567, 64'h1, {64'h0, 64'hDEAD_BEEF_0123_4567}, 1'b0, 10};
        vecs[5] = mk({$urandom(), $urandom()}, {$urandom(), $urandom()}, 3);
        vecs[6] = mk({$urandom(), $urandom()}, 64'h0000_0000_FFFF_FFFF, 0);
        vecs[7] = mk(64'h1, 64'h1, 1);

        // Reset held with in_valid high: no accept may occur
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 64'h1234; b = 64'h5678;
        tick();
        tick();
        chk("reset.outputs", {124'd0, in_ready, out_valid, busy, hi_nz}, 128'b1000);
        chk("reset.prod", {prod_hi, prod_lo}, 128'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("reset.no_accept", {127'd0, busy}, 128'd0);
        $display("reset: in_ready=%0d out_valid=%0d busy=%0d", in_ready, out_valid, busy);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].exp_nz, vecs[i].hold);
        end

        // Back-to-back: a new accept is possible the edge after consume
        run_op("b2b", 64'h3, 64'h5, 128'd15, 1'b0, 0);

        // Reset mid-RUN at iteration 30: product discarded, no out_valid
        in_valid = 1'b1;
        a = 64'h1111_1111_1111_1111;
        b = 64'hEEEE_EEEE_EEEE_EEEE;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("midrun.busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun.idle", {125'd0, in_ready, busy, out_valid}, 128'b100);
        seen = 1'b0;
        n = 0;
        while (n < 80) begin
            tick();
            n++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("midrun.no_out_valid", {127'd0, seen}, 128'd0);
        $display("midrun reset: discarded op, out_valid seen=%0d", seen);
        run_op("reissue", 64'h1111_1111_1111_1111, 64'hEEEE_EEEE_EEEE_EEEE,
               {64'd0, 64'h1111_1111_1111_1111} * {64'd0, 64'hEEEE_EEEE_EEEE_EEEE}, 1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
